// File: rtl/pipe_divider_pkg.sv
// pipe_divider_pkg: shared sizing helpers and the single restoring-division step
// nstages    : number of compute stages for a width / steps-per-stage pair
// stage_bits : packed width of one pipeline stage record for a given operand width
// div_step   : one MSB-first restoring step, returns {rem_next, qbit}
package pipe_divider_pkg;
    localparam int MAX_W = 64;
    function automatic int nstages(input int d_width, input int steps_per_stage);
        return d_width / steps_per_stage;
    endfunction
    function automatic int stage_bits(input int d_width);
        return 3 * d_width + 5;
    endfunction
    // Operands are zero-extended to MAX_W by the caller; the partial remainder stays
    // below the divisor, so the extra top bit of the shifted value is a clean borrow detector.
    function automatic logic [MAX_W+1:0] div_step(
        input logic [MAX_W:0]   rem,
        input logic             dbit,
        input logic [MAX_W-1:0] divisor
    );
        logic [MAX_W+1:0] shifted;
        logic [MAX_W+1:0] diff;
        shifted = {rem, dbit};
        diff    = shifted - {2'b00, divisor};
        return diff[MAX_W+1] ? {shifted[MAX_W:0], 1'b0} : {diff[MAX_W:0], 1'b1};
    endfunction
endpackage

// File: rtl/pipe_divider_stage.sv
// pipe_divider_stage: STEPS restoring-division steps followed by a stall-holding register
// clk, rst : clock, asynchronous active-high reset (clears the whole stage record)
// stall    : hold the register contents this cycle
// d        : incoming stage record {valid, dz, qsign, rsign, partial_rem, quot_shift, divisor}
// q        : registered stage record after STEPS steps
module pipe_divider_stage
    import pipe_divider_pkg::*;
#(
    parameter int D_WIDTH = 16,
    parameter int STEPS   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic [stage_bits(D_WIDTH)-1:0] d,
    output logic [stage_bits(D_WIDTH)-1:0] q
);
    typedef struct packed {
        logic               valid;
        logic               dz;
        logic               qsign;
        logic               rsign;
        logic [D_WIDTH:0]   partial_rem;
        logic [D_WIDTH-1:0] quot_shift;
        logic [D_WIDTH-1:0] divisor;
    } stage_t;

    stage_t cur;
    stage_t nxt;
    logic   qbit;

    assign cur = d;

    // quot_shift feeds dividend bits out of its MSB while quotient bits enter at its LSB
    always_comb begin
        nxt  = cur;
        qbit = 1'b0;
        for (int i = 0; i < STEPS; i++) begin
            {nxt.partial_rem, qbit} = (D_WIDTH + 2)'(div_step((MAX_W + 1)'(nxt.partial_rem),
                                                              nxt.quot_shift[D_WIDTH-1],
                                                              MAX_W'(nxt.divisor)));
            nxt.quot_shift = {nxt.quot_shift[D_WIDTH-2:0], qbit};
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)
            q <= '0;
        else if (!stall)
            q <= nxt;
endmodule

// File: rtl/pipe_divider.sv
// pipe_divider: fully pipelined restoring integer divider with valid/ready handshake
// clk, rst              : clock, asynchronous active-high reset
// in_valid/in_ready     : input handshake, in_ready = !(out_valid && !out_ready)
// dividend, divisor     : operands (D_WIDTH bits)
// out_valid/out_ready   : output handshake, whole pipe holds while stalled
// quotient, remainder   : results; div_by_zero flags a zero divisor
// Latency is 1 + D_WIDTH/STEPS_PER_STAGE cycles.
// Macro PIPE_DIVIDER_SIGNED_EN selects two's complement operands, truncating toward zero.
module pipe_divider
    import pipe_divider_pkg::*;
#(
    parameter int D_WIDTH         = 16,
    parameter int STEPS_PER_STAGE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] quotient,
    output logic [D_WIDTH-1:0] remainder,
    output logic               div_by_zero
);
    if (STEPS_PER_STAGE < 1 || D_WIDTH < 2 || D_WIDTH > MAX_W || D_WIDTH % STEPS_PER_STAGE != 0) begin : g_bad_cfg
        $error("pipe_divider: need 2 <= D_WIDTH <= 64 and STEPS_PER_STAGE dividing D_WIDTH");
    end

    localparam int NSTAGES = nstages(D_WIDTH, STEPS_PER_STAGE);
    localparam int SW      = stage_bits(D_WIDTH);

    typedef struct packed {
        logic               valid;
        logic               dz;
        logic               qsign;
        logic               rsign;
        logic [D_WIDTH:0]   partial_rem;
        logic [D_WIDTH-1:0] quot_shift;
        logic [D_WIDTH-1:0] divisor;
    } stage_t;

    logic [SW-1:0]      pipe [NSTAGES+1];
    stage_t             head;
    stage_t             last;
    logic               stall;
    logic               qs;
    logic               rs;
    logic [D_WIDTH-1:0] mag_a;
    logic [D_WIDTH-1:0] mag_b;
    logic [D_WIDTH-1:0] q_mag;
    logic [D_WIDTH-1:0] r_mag;
    logic               unused_last;

    assign last      = pipe[NSTAGES];
    assign stall     = last.valid && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = last.valid;

`ifdef PIPE_DIVIDER_SIGNED_EN
    assign qs    = dividend[D_WIDTH-1] ^ divisor[D_WIDTH-1];
    assign rs    = dividend[D_WIDTH-1];
    assign mag_a = rs ? -dividend : dividend;
    assign mag_b = divisor[D_WIDTH-1] ? -divisor : divisor;
`else
    assign qs    = 1'b0;
    assign rs    = 1'b0;
    assign mag_a = dividend;
    assign mag_b = divisor;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst)
            head <= '0;
        else if (!stall)
            head <= '{valid: in_valid && in_ready, dz: divisor == '0, qsign: qs, rsign: rs,
                      partial_rem: '0, quot_shift: mag_a, divisor: mag_b};

    assign pipe[0] = head;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        pipe_divider_stage #(
            .D_WIDTH(D_WIDTH),
            .STEPS  (STEPS_PER_STAGE)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .stall(stall),
            .d    (pipe[k]),
            .q    (pipe[k+1])
        );
    end

    assign q_mag       = last.quot_shift;
    assign r_mag       = last.partial_rem[D_WIDTH-1:0];
    assign div_by_zero = last.dz;

    // A zero divisor keeps the all-ones quotient unsigned; negating the remainder
    // magnitude with the dividend sign restores the original dividend.
`ifdef PIPE_DIVIDER_SIGNED_EN
    assign quotient  = last.dz ? '1 : last.qsign ? -q_mag : q_mag;
    assign remainder = last.rsign ? -r_mag : r_mag;
`else
    assign quotient  = last.dz ? '1 : q_mag;
    assign remainder = r_mag;
`endif

    assign unused_last = ^{last.qsign, last.rsign, last.divisor, last.partial_rem[D_WIDTH]};
endmodule

// File: tb/tb_pipe_divider.sv
// tb_pipe_divider: randomized self-checking bench for pipe_divider against an arithmetic model
module tb_pipe_divider;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dz;

    logic         v4 = 1'b0;
    logic         in_ready4;
    logic [W-1:0] a4 = '0;
    logic [W-1:0] b4 = '0;
    logic         ov4;
    logic [W-1:0] q4;
    logic [W-1:0] rm4;
    logic         dz4;

    int n_cmp = 0;
    int n_err = 0;
    int n_res = 0;
    logic [2*W:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_divider #(.D_WIDTH(W), .STEPS_PER_STAGE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(dz)
    );

    pipe_divider #(.D_WIDTH(W), .STEPS_PER_STAGE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(in_ready4),
        .dividend(a4), .divisor(b4), .out_valid(ov4), .out_ready(1'b1),
        .quotient(q4), .remainder(rm4), .div_by_zero(dz4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {div_by_zero, quotient, remainder} straight from the arithmetic definition
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, sq, sr;
        if (b == '0)
            return {1'b1, {W{1'b1}}, a};
`ifdef PIPE_DIVIDER_SIGNED_EN
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`else
        sa = longint'(a);
        sb = longint'(b);
`endif
        sq = sa / sb;
        sr = sa % sb;
        return {1'b0, sq[W-1:0], sr[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rnd_div();
        int s;
        s = $urandom_range(0, 9);
        return s == 0 ? '0 : s < 5 ? W'($urandom_range(1, 15)) : W'($urandom);
    endfunction

    always @(negedge clk)
        if (!rst) begin
            if (in_valid && in_ready)
                exp_q.push_back(model(dividend, divisor));
            if (out_valid && out_ready) begin
                n_res++;
                if (exp_q.size() == 0)
                    check("spurious_result", 1, 0);
                else
                    check("result", {dz, quotient, remainder}, exp_q.pop_front());
            end
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic measure(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            in_valid = 1'b0;
        end while (!out_valid && lat < 60);
    endtask

    task automatic measure4(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        v4 = 1'b1;
        a4 = a;
        b4 = b;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            v4 = 1'b0;
        end while (!ov4 && lat < 60);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        int n0;
        int stale;
        logic acc;
        logic [2*W:0] snap;

        repeat (2) tick();
        check("reset_state", {out_valid, in_ready, dz, quotient, remainder}, {1'b0, 1'b1, 1'b0, 32'h0});
        @(negedge clk);
        rst = 1'b0;
        tick();

        measure(16'd100, 16'd7, lat);
        check("lat_100_7", lat, 1 + W);
        check("res_100_7", {dz, quotient, remainder}, {1'b0, 16'd14, 16'd2});
        tick();
        check("single_pulse", out_valid, 0);

        measure(16'd5, 16'd0, lat);
        check("res_5_0", {dz, quotient, remainder}, {1'b1, 16'hFFFF, 16'd5});
        measure(16'hFFFF, 16'd1, lat);
        check("res_ffff_1", {dz, quotient, remainder}, {1'b0, 16'hFFFF, 16'd0});
        tick();

        measure4(16'd100, 16'd7, lat);
        check("lat4_100_7", lat, 1 + W / 4);
        check("res4_100_7", {dz4, q4, rm4}, {1'b0, 16'd14, 16'd2});

        n0 = n_res;
        for (int i = 0; i < 32; i++)
            send(W'($urandom), rnd_div());
        drain();
        check("stream_count", n_res - n0, 32);

        n0 = n_res;
        for (int i = 0; i < 6; i++)
            send(W'($urandom), rnd_div());
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("bp_reach_valid", out_valid, 1);
        out_ready = 1'b0;
        snap = {dz, quotient, remainder};
        in_valid = 1'b1;
        dividend = 16'd1234;
        divisor  = 16'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {out_valid, in_ready, dz, quotient, remainder}, {1'b1, 1'b0, snap});
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();
        check("bp_count", n_res - n0, 7);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || acc) begin
                in_valid = $urandom_range(0, 3) != 0;
                dividend = W'($urandom);
                divisor  = rnd_div();
            end
            out_ready = $urandom_range(0, 3) != 0;
        end
        in_valid = 1'b0;
        drain();

        for (int i = 0; i < 8; i++)
            send(W'($urandom), rnd_div());
        #1;
        rst = 1'b1;
        #1;
        check("rst_flush", {out_valid, in_ready, dz, quotient, remainder}, {1'b1 ^ 1'b1, 1'b1, 1'b0, 32'h0});
        exp_q.delete();
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (out_valid)
                stale++;
        end
        check("no_stale", stale, 0);
        measure(16'd9, 16'd3, lat);
        check("lat_9_3", lat, 1 + W);
        check("res_9_3", {dz, quotient, remainder}, {1'b0, 16'd3, 16'd0});
        tick();

`ifdef PIPE_DIVIDER_SIGNED_EN
        measure(-16'sd7, 16'sd2, lat);
        check("res_m7_2", {dz, quotient, remainder}, {1'b0, 16'hFFFD, 16'hFFFF});
        measure(16'sd7, -16'sd2, lat);
        check("res_7_m2", {dz, quotient, remainder}, {1'b0, 16'hFFFD, 16'd1});
        measure(16'h8000, 16'hFFFF, lat);
        check("res_ovf", {dz, quotient, remainder}, {1'b0, 16'h8000, 16'd0});
        tick();
`endif

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_divider.md
Name: pipe_divider

Overview:
- Parametrised, fully pipelined integer divider: the next generation of the input-registered divide-plus-shift-register block.
- Computes quotient, remainder and a divide-by-zero flag.
- Accepts one operation per cycle through a valid/ready handshake and propagates valid through the pipe.
- Supports output backpressure and a configurable number of restoring-division steps per pipeline stage, trading latency against Fmax.

Parameters:
- D_WIDTH, 16, operand/result width in bits (>= 2).
- STEPS_PER_STAGE, 1, restoring-division bit steps per compute stage. Must divide D_WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  pipe can accept this cycle.
- dividend  input  D_WIDTH  numerator.
- divisor  input  D_WIDTH  denominator.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  D_WIDTH  dividend / divisor.
- remainder  output  D_WIDTH  dividend mod divisor.
- div_by_zero  output  1  divisor was zero for this result.

Behaviour:
- NSTAGES = D_WIDTH/STEPS_PER_STAGE.
- Pipe structure: input register stage, then NSTAGES compute stages; the last compute stage drives the outputs directly.
- Latency: L = 1 + NSTAGES cycles from accepted input to out_valid. Defaults give 17; STEPS_PER_STAGE=4 gives 5.
- Accept: an input is accepted on a rising edge where in_valid && in_ready.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - When stall=1, every stage register (data and valid) holds.
  - When stall=0, all stages advance. Bubbles (valid=0) advance too; there is no bubble collapsing.
- Throughput: 1 result/cycle while out_ready=1.
- Valid bit: each stage carries a valid bit. The input-stage valid loads in_valid && in_ready when not stalled.
- Data gating: data registers may load unconditionally when not stalled. Outputs are only meaningful while out_valid=1.
- Arithmetic: unsigned restoring division, MSB first.
  - Each step shifts the partial remainder (D_WIDTH+1 bits) left by one and brings in the next dividend bit.
  - It then subtracts the divisor; if the result is non-negative, it keeps the difference and sets the quotient bit to 1. Otherwise it restores and sets the quotient bit to 0.
  - Exact for all operand pairs.
- Divide by zero: the divisor==0 flag is captured in the input stage and carried down the pipe. Result: quotient = all ones, remainder = dividend, div_by_zero=1. This matches natural restoring output; the implementation must guarantee it.
- Reset (asynchronous, any time including mid-stream): all valid bits go to 0, so out_valid=0 and in_ready=1. quotient, remainder and div_by_zero reset to 0. In-flight operations are discarded. The first accept after rst deasserts produces a result exactly L cycles later.
- Simultaneous events: if out_ready goes low in the same cycle a new input is presented while out_valid=1, in_ready=0 and the input is not accepted. The source must hold it (standard valid/ready; in_valid must not drop before acceptance).
- Ordering: results emerge strictly in accept order.

Optional Feature:
- Macro: PIPE_DIVIDER_SIGNED_EN.
- Defined:
  - Operands are two's complement. The input stage takes magnitudes and records the quotient sign (sign(dividend) xor sign(divisor)) and the remainder sign (sign(dividend)).
  - The last stage negates the outputs accordingly, truncating toward zero. This adds no extra cycle; the negation is combinational in the final stage.
  - Overflow: -2^(D_WIDTH-1) / -1 gives quotient = 0x8000 (D_WIDTH=16) and remainder = 0, with no flag.
  - Divide by zero gives quotient = all ones and remainder = dividend, unsigned semantics preserved.
- Undefined: unsigned only; no sign logic is instantiated.

Decomposition:
- Package pipe_divider_pkg:
  - Function nstages(D_WIDTH, STEPS_PER_STAGE).
  - Parametrised stage typedef, a packed struct {valid, dz, qsign, rsign, partial_rem, quot_shift, divisor}, sized via localparams in the module.
  - One-step restoring function div_step(rem, dbit, divisor) returning {rem_next, qbit}.
- Sub-module pipe_divider_stage:
  - Applies STEPS_PER_STAGE div_step iterations combinationally, then registers the result with hold-on-stall and async reset of valid.
  - Instantiated NSTAGES times by a generate loop.

Test Plan:
- Single op, 100/7, out_ready=1 -> after 17 cycles (defaults): out_valid=1 for one cycle, quotient=14, remainder=2, div_by_zero=0.
- Divide by zero, 5/0 -> quotient=0xFFFF, remainder=5, div_by_zero=1. Extreme 0xFFFF/1 -> quotient=0xFFFF, remainder=0.
- Stream: 32 back-to-back random ops, out_ready=1 -> 32 consecutive valid results in order, matching the reference model. Repeat with STEPS_PER_STAGE=4 and check latency is 5.
- Backpressure: hold out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, outputs held stable, no loss or duplication. Release -> in-order drain.
- Reset mid-stream: assert rst with 8 ops in flight -> out_valid=0 immediately and no stale results after release. A new 9/3 gives quotient=3, remainder=0 after 17 cycles.
- Signed build: -7/2 -> quotient=-3, remainder=-1. 7/-2 -> quotient=-3, remainder=1. -32768/-1 -> quotient=0x8000, remainder=0.
